// File: rtl/rpma_tf_pkg.sv
// Shared definitions for the RPMA twiddle-factor address generator:
// opcodes, FSM encoding and a constant clog2 helper.
package rpma_tf_pkg;

  localparam logic [1:0] NTT  = 2'b00;
  localparam logic [1:0] INTT = 2'b01;
  localparam logic [1:0] PWM1 = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < 32; b++) begin
      if ((32'd1 << b) < v) r = b + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tf_pipe_stall.sv
// Width x depth register chain with per-stage valid bits, a global enable
// that freezes the whole chain, and a synchronous flush of the valid bits.
module tf_pipe_stall #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < DEPTH; s++) r_data[s] <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_en) begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int s = 1; s < DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/tf_addr_gen_mlane.sv
// Self-sequencing multi-lane twiddle ROM address generator: walks every
// stage/beat of an NTT, INTT or PWM1 pass and streams LANES addresses per beat.
module tf_addr_gen_mlane
  import rpma_tf_pkg::*;
#(
  parameter int unsigned LOG_N    = 8,
  parameter int unsigned LANES    = 4,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned LAT      = 2,
  parameter int unsigned OFF_INTT = 384,
  parameter int unsigned OFF_PWM  = 768
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [1:0]                i_opcode,
  input  logic                      i_radix4,
  input  logic                      i_out_ready,
  output logic                      o_out_valid,
  output logic [LANES*ADDR_W-1:0]   o_tf_addr,
  output logic [LOG_N-1:0]          o_stage,
  output logic                      o_last,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  localparam int unsigned N   = 1 << LOG_N;
  localparam int unsigned LLG = clog2(LANES);
  localparam int unsigned BW  = LANES * ADDR_W;
  localparam int unsigned PW  = 1 + LOG_N + BW;

  state_e            r_state, w_state_next;
  logic [1:0]        r_op;
  logic              r_r4;
  logic [LOG_N-1:0]  r_i, r_g;
  logic [LOG_N-1:0]  w_s_last, w_g_last;
  logic              w_en, w_issue, w_beat_last, w_start_ok, w_start_bad, w_fire_last;
  logic [ADDR_W-1:0] w_base;
  logic [BW-1:0]     w_addr_bus;
  logic [PW-1:0]     w_pipe_in, w_pipe_out;
  logic              w_pipe_valid, w_last_raw;
  logic              r_done, r_err;

  wire w_idle = (r_state == StIdle);

  assign w_start_ok  = i_start & w_idle & (i_opcode != 2'b11) & ~i_abort;
  assign w_start_bad = i_start & w_idle & (i_opcode == 2'b11) & ~i_abort;
  assign w_en        = i_out_ready | ~w_pipe_valid;
  assign w_issue     = (r_state == StRun) & w_en;
  assign w_beat_last = (r_i == w_s_last) & (r_g == w_g_last);
  assign w_fire_last = w_pipe_valid & i_out_ready & w_last_raw;

  // Final stage/beat indices of the configured schedule.
  always_comb begin
    w_s_last = LOG_N'(LOG_N - 1);
    w_g_last = LOG_N'(N / (2 * LANES) - 1);
    if (r_op == PWM1) begin
      w_s_last = '0;
    end else if (r_r4) begin
      w_s_last = LOG_N'(LOG_N / 2 - 1);
      w_g_last = LOG_N'(N / (4 * LANES) - 1);
    end
  end

  // Lane-0 address; all arithmetic wraps naturally at ADDR_W bits.
  always_comb begin
    case (r_op)
      INTT:    w_base = ADDR_W'(OFF_INTT);
      PWM1:    w_base = ADDR_W'(OFF_PWM);
      default: w_base = '0;
    endcase
    if (r_op != PWM1) begin
      w_base = w_base + (r_r4 ? (ADDR_W'(r_i) << (LOG_N - 2)) : (ADDR_W'(r_i) << (LOG_N - 1)));
    end
    w_base = w_base + (ADDR_W'(r_g) << LLG);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_addr_bus[k*ADDR_W +: ADDR_W] = w_base + ADDR_W'(k);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_next = StRun;
      StRun:   if (w_issue && w_beat_last) w_state_next = StDrain;
      StDrain: if (w_fire_last) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (i_abort) w_state_next = StIdle;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op   <= NTT;
      r_r4   <= 1'b0;
      r_i    <= '0;
      r_g    <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (i_abort) begin
        r_i <= '0;
        r_g <= '0;
      end else begin
        if (w_start_ok) begin
          r_op <= i_opcode;
          r_r4 <= i_radix4 & (i_opcode != PWM1);
          r_i  <= '0;
          r_g  <= '0;
        end else if (w_issue) begin
          if (w_beat_last) begin
            r_i <= '0;
            r_g <= '0;
          end else if (r_g == w_g_last) begin
            r_g <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_g <= r_g + 1'b1;
          end
        end
        r_err  <= w_start_bad;
        r_done <= w_fire_last & (r_state == StDrain);
      end
    end
  end

  assign w_pipe_in = {w_beat_last, r_i, w_addr_bus};

  tf_pipe_stall #(
    .WIDTH(PW),
    .DEPTH(LAT)
  ) u_pipe (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (w_en),
    .i_flush(i_abort),
    .i_valid(r_state == StRun),
    .i_data (w_pipe_in),
    .o_valid(w_pipe_valid),
    .o_data (w_pipe_out)
  );

  assign w_last_raw  = w_pipe_out[PW-1];
  assign o_out_valid = w_pipe_valid;
  assign o_tf_addr   = w_pipe_out[BW-1:0];
  assign o_stage     = w_pipe_out[BW +: LOG_N];
  assign o_last      = w_last_raw & w_pipe_valid;
  assign o_busy      = ~w_idle;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: doc/tf_addr_gen_mlane.md
# tf_addr_gen_mlane

Multi-lane, self-sequencing twiddle-factor address generator for the RPMA datapath. A single `start` configures it. It then walks every stage and butterfly group of an NTT, INTT or PWM1 pass on its own, in radix-2 or radix-4 mode. Each beat it emits `LANES` twiddle ROM addresses through a stallable `LAT`-deep pipeline with a valid/ready handshake. It sits between the controller and the multi-port twiddle ROM; in radix-4 mode each address selects a ROM word packing three twiddles.

## Interface
- `LOG_N`, 8, log2 of polynomial length N (even, ≥4)
- `LANES`, 4, addresses per beat; power of two, ≤ N/4
- `ADDR_W`, 10, ROM address width
- `LAT`, 2, pipeline registers from counter to output (≥1)
- `OFF_INTT`, 384, INTT table base
- `OFF_PWM`, 768, PWM1 table base
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous, active-low reset
- `start` in 1, pulse; accepted only in IDLE
- `abort` in 1, synchronous flush to IDLE
- `opcode` in 2, 00 NTT, 01 INTT, 10 PWM1, 11 reserved; sampled with `start`
- `radix4` in 1, 1 = radix-4 schedule; sampled with `start`, ignored for PWM1
- `out_ready` in 1, downstream accepts the current beat
- `out_valid` out 1, beat valid
- `tf_addr` out LANES*ADDR_W, lane k at bits [k*ADDR_W +: ADDR_W]
- `stage` out LOG_N, stage index of the current beat
- `last` out 1, final beat of the pass (qualified by `out_valid`)
- `busy` out 1, high from start acceptance until the last beat is accepted
- `done` out 1, one-cycle pulse after the last beat is accepted
- `err` out 1, one-cycle pulse when `start` arrives with opcode 11

## Operation
- **FSM:** IDLE → RUN on a legal `start`. RUN → DRAIN when the generator has issued its last beat. DRAIN → IDLE when the output beat with `last` fires; `done` pulses on that transition.
- **Stage count S:**
  - radix-2: S = LOG_N
  - radix-4: S = LOG_N/2
  - PWM1: S = 1
- **Butterflies per stage B:**
  - radix-2: B = N/2
  - radix-4: B = N/4
  - PWM1: B = N/2
- **Beats per stage:** B/LANES.
- **Counters:**
  - Stage counter `i` runs 0..S-1.
  - Beat counter `g` runs 0..B/LANES-1 and wraps to 0 when `i` increments.
  - Butterfly index for lane k: b = g*LANES + k.
- **Lane k address**, truncated mod 2^ADDR_W:
  - NTT: i*B + b
  - INTT: OFF_INTT + i*B + b
  - PWM1: OFF_PWM + b
- **Counter advance:** counters advance only when pipeline stage 0 is loaded.
- **Illegal or redundant start:**
  - `start` with opcode 11: `err` pulses, the block stays IDLE.
  - `start` while not IDLE: ignored, no `err`.
- **Abort:** clears all valid bits, counters and the FSM next cycle, wins over every other event, and produces no `done`. `start` on the cycle after `abort` is honoured.

## Timing
- **Reset values:** `out_valid`=0, `tf_addr`=0, `stage`=0, `last`=0, `busy`=0, `done`=0, `err`=0, FSM IDLE, counters 0.
- **Pipeline:** `LAT` registers, each carrying {valid, addr, stage, last}.
- **Global enable:** en = `out_ready` | ~`out_valid`. Bubbles are not compressed internally; the pipeline simply holds when en=0.
- **Start-to-output latency:** the first beat is valid LAT cycles after the `start` cycle, provided `out_ready` stays 1.
- **Throughput:** one beat per cycle with `out_ready` held high. A pass therefore takes S*B/LANES + LAT cycles from `start` to `done`.
- **Stall:** while `out_valid`=1 and `out_ready`=0, `tf_addr`, `stage` and `last` are held stable.
- **`busy`:** rises the cycle after `start` and falls on the same edge that `done` is asserted.
- **`start` and `done` in the same cycle:** `start` is ignored, because the FSM is not IDLE.

## Structure
- **Shared package (`rpma_tf_pkg`):**
  - opcode localparams `NTT`, `INTT`, `PWM1`
  - FSM state encoding
  - a clog2 helper
- **Sub-module `tf_pipe_stall`:** a parameterised width×depth register chain with valid bits and global enable, instantiated once for the {valid, addr bus, stage, last} bundle.
- **In the top:** address arithmetic, with `LANES` adders generated by a loop.

## Test plan
- **Radix-2 NTT:** LOG_N=8, LANES=4, opcode 00, radix4=0, `out_ready`=1.
  - Beat 0 gives lanes {0,1,2,3}; beat 32 (stage 1) gives {128,129,130,131}.
  - 256 beats in total; `last` only on the beat with lanes {1020,1021,1022,1023}, which wraps to {1020,1021,1022,1023} mod 1024.
  - `done` 258 cycles after `start`.
- **INTT radix-4:** opcode 01, radix4=1.
  - 4 stages × 16 beats.
  - First beat {384..387}; stage 3, g=15 gives {384+192+60 .. 384+192+63} = {636..639}.
- **PWM1:** opcode 10.
  - 32 beats; addresses run 768..895 in order, with `stage`=0 throughout.
- **Backpressure:** toggle `out_ready` randomly during an NTT run.
  - The accepted address stream equals the unstalled stream.
  - Outputs hold stable while stalled; `done` arrives after the final accepted beat.
- **Abort and illegal opcode:**
  - `abort` mid-stage-3: `out_valid` falls next cycle, there is no `done`, and an immediate restart reproduces beat 0.
  - `start` with opcode 11 pulses `err` once and `busy` stays 0.
- **Reset:** assert `rst` low asynchronously during RUN with `out_ready`=0.
  - All outputs go to reset values without a clock edge.
  - After release, the block is IDLE and accepts `start`.
